// File: rtl/cache_pkg.sv
// Shared types, constants and lane helpers for the data cache refill controller.
package cache_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StRefill,
        StWrite,
        StRespond
    } state_t;

    // Access size encodings; 2'b11 falls through to word everywhere
    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;

    localparam int unsigned TAG_W     = 24;
    localparam int unsigned SET_W     = 4;
    localparam int unsigned OFF_W     = 2;
    localparam int unsigned NUM_WORDS = 4;

    typedef struct packed {
        logic                            valid;
        logic [TAG_W-1:0]                tag;
        logic [NUM_WORDS-1:0][31:0]      word;
    } line_t;

    // Byte enables for a store of the given size at byte offset off
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: return 4'b0001 << off;
            SIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    // Move LS-aligned store data onto the byte lanes selected by off
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [1:0] off,
                                               input logic [31:0] wdata);
        case (size)
            SIZE_BYTE: return {24'b0, wdata[7:0]} << {off, 3'b000};
            SIZE_HALF: return off[1] ? {wdata[15:0], 16'b0} : {16'b0, wdata[15:0]};
            default:   return wdata;
        endcase
    endfunction

    // Pull the addressed lane out of a word and zero-extend it
    function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        case (size)
            SIZE_BYTE: return {24'b0, shifted[7:0]};
            SIZE_HALF: return off[1] ? {16'b0, word[31:16]} : {16'b0, word[15:0]};
            default:   return word;
        endcase
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag/valid/data storage for the direct-mapped cache: one line per set,
// byte-enabled word writes, whole-line tag install, combinational indexed read.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int unsigned SetBits = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SetBits-1:0] set_i,
    input  logic               word_we_i,
    input  logic [OFF_W-1:0]   word_sel_i,
    input  logic [3:0]         word_be_i,
    input  logic [31:0]        word_wdata_i,
    input  logic               install_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic               inval_i,
    output line_t              line_o
);

    localparam int unsigned NumSets = 1 << SetBits;

    logic [NumSets-1:0]                        valid_q, valid_d;
    logic [NumSets-1:0][TAG_W-1:0]             tag_q, tag_d;
    logic [NumSets-1:0][NUM_WORDS-1:0][31:0]   data_q, data_d;

    // Next-state for valid bits, tags and data words of the indexed set
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (inval_i) begin
            valid_d[set_i] = 1'b0;
        end
        if (install_i) begin
            valid_d[set_i] = 1'b1;
            tag_d[set_i]   = tag_i;
        end
        if (word_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (word_be_i[b]) begin
                    data_d[set_i][word_sel_i][8*b +: 8] = word_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Valid bits are the only storage that must come out of reset defined
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; they are qualified by valid
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    // Combinational read of the indexed line
    always_comb begin
        line_o.valid = valid_q[set_i];
        line_o.tag   = tag_q[set_i];
        line_o.word  = data_q[set_i];
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Load/store sequencer for the memory-stage data cache: tag check, 4-beat
// read-miss refill, write-through stores, and an uncached bypass mode.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SET_BITS   = 4,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [1:0]            cpu_size,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_resp,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  cache_en,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    localparam logic [OFF_W-1:0] LastBeat = OFF_W'(LINE_WORDS - 1);

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [OFF_W-1:0]      cnt_q, cnt_d;
    logic                  byp_q, byp_d;
    logic [DATA_WIDTH-1:0] byp_word_q, byp_word_d;

    logic                  ls_word_we;
    logic [3:0]            ls_be;
    logic [31:0]           ls_wdata;
    logic                  ls_install;
    logic                  ls_inval;
    line_t                 line;

    logic                  hit;
    logic [31:0]           resp_word;

    cache_line_store #(
        .SetBits (SET_BITS)
    ) u_store (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_i        (addr_q[4 +: SET_BITS]),
        .word_we_i    (ls_word_we),
        .word_sel_i   (addr_d_sel()),
        .word_be_i    (ls_be),
        .word_wdata_i (ls_wdata),
        .install_i    (ls_install),
        .tag_i        (addr_q[ADDR_WIDTH-1:8]),
        .inval_i      (ls_inval),
        .line_o       (line)
    );

    // Refill writes go to the beat counter's word; store merges to the addressed word
    function automatic logic [OFF_W-1:0] addr_d_sel();
        return (state_q == StRefill) ? cnt_q : addr_q[3:2];
    endfunction

    // Hit qualification uses the live enable so changes apply at the next check
    always_comb begin
        hit       = line.valid && (line.tag == addr_q[ADDR_WIDTH-1:8]) && cache_en;
        resp_word = byp_q ? byp_word_q : line.word[addr_q[3:2]];
    end

    // State register and captured request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            addr_q     <= '0;
            size_q     <= SIZE_WORD;
            wdata_q    <= '0;
            cnt_q      <= '0;
            byp_q      <= 1'b0;
            byp_word_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            byp_q      <= byp_d;
            byp_word_q <= byp_word_d;
        end
    end

    // Next-state, storage control and all outputs
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        byp_d      = byp_q;
        byp_word_d = byp_word_q;

        cpu_ready  = 1'b0;
        cpu_resp   = 1'b0;
        cpu_rdata  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;

        ls_word_we = 1'b0;
        ls_be      = '0;
        ls_wdata   = '0;
        ls_install = 1'b0;
        ls_inval   = 1'b0;

        unique case (state_q)
            StIdle: begin
                cpu_ready = 1'b1;
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    size_d  = cpu_size;
                    wdata_d = cpu_wdata;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                byp_d = !cache_en;
                if (we_q) begin
                    // Write-through with no allocate: only a resident line is updated
                    if (hit) begin
                        ls_word_we = 1'b1;
                        ls_be      = lane_be(size_q, addr_q[1:0]);
                        ls_wdata   = lane_wdata(size_q, addr_q[1:0], wdata_q);
                    end
                    state_d = StWrite;
                end else if (hit) begin
                    state_d = StRespond;
                end else begin
                    cnt_d    = '0;
                    // Drop the old line so a partial refill is never seen as valid
                    ls_inval = cache_en;
                    state_d  = StRefill;
                end
            end
            StRefill: begin
                mem_req = 1'b1;
                mem_be  = 4'b1111;
                if (byp_q) begin
                    mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                end else begin
                    mem_addr = {addr_q[ADDR_WIDTH-1:4], cnt_q, 2'b00};
                end
                if (mem_ack) begin
                    if (byp_q) begin
                        byp_word_d = mem_rdata;
                        state_d    = StRespond;
                    end else begin
                        ls_word_we = 1'b1;
                        ls_be      = 4'b1111;
                        ls_wdata   = mem_rdata;
                        cnt_d      = cnt_q + 1'b1;
                        if (cnt_q == LastBeat) begin
                            ls_install = 1'b1;
                            state_d    = StRespond;
                        end
                    end
                end
            end
            StWrite: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                mem_be    = lane_be(size_q, addr_q[1:0]);
                mem_wdata = lane_wdata(size_q, addr_q[1:0], wdata_q);
                if (mem_ack) begin
                    state_d = StRespond;
                end
            end
            StRespond: begin
                cpu_resp = 1'b1;
                if (!we_q) begin
                    cpu_rdata = lane_extract(size_q, addr_q[1:0], resp_word);
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule
